// File: rtl/data_axi_bridge_pkg.sv
// Shared types and constants for the data-side AXI bridge: FSM encoding,
// AXI size/burst codes and the fixed transaction ID.
package data_axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_D = 3'd2,
    ST_WR   = 3'd3,
    ST_WR_B = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  localparam logic [3:0] DATA_AXI_ID    = 4'd1;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_1B    = 3'b000;
  localparam logic [2:0] AXI_SIZE_2B    = 3'b001;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  // CPU size codes 0/1/2 map directly onto AXI byte/half/word sizes.
  function automatic logic [2:0] axi_size(input logic [1:0] mem_size);
    return {1'b0, mem_size};
  endfunction

endpackage

// File: rtl/data_axi_bridge_axi_wr_pair.sv
// Drives AWVALID/WVALID together from a start pulse and tracks each handshake
// independently; both_done fires in the cycle the second handshake lands.
module axi_wr_pair (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic awready,
  input  logic wready,
  output logic awvalid,
  output logic wvalid,
  output logic both_done
);

  logic awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d;
  logic aw_ok_q, aw_ok_d;
  logic w_ok_q, w_ok_d;
  logic aw_hs, w_hs;

  // Handshake flags: each valid drops on its own handshake, flags clear once both are in.
  always_comb begin
    aw_hs     = awvalid_q & awready;
    w_hs      = wvalid_q & wready;
    both_done = (aw_ok_q | aw_hs) & (w_ok_q | w_hs);
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    aw_ok_d   = aw_ok_q;
    w_ok_d    = w_ok_q;
    if (start) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      aw_ok_d   = 1'b0;
      w_ok_d    = 1'b0;
    end else if (both_done) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      aw_ok_d   = 1'b0;
      w_ok_d    = 1'b0;
    end else begin
      if (aw_hs) begin
        awvalid_d = 1'b0;
        aw_ok_d   = 1'b1;
      end else begin
        awvalid_d = awvalid_q;
        aw_ok_d   = aw_ok_q;
      end
      if (w_hs) begin
        wvalid_d = 1'b0;
        w_ok_d   = 1'b1;
      end else begin
        wvalid_d = wvalid_q;
        w_ok_d   = w_ok_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_ok_q   <= 1'b0;
      w_ok_q    <= 1'b0;
    end else begin
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_ok_q   <= aw_ok_d;
      w_ok_q    <= w_ok_d;
    end
  end

  assign awvalid = awvalid_q;
  assign wvalid  = wvalid_q;

endmodule

// File: rtl/data_axi_bridge.sv
// Data-memory port responder: turns one SRAM-style load/store into a single-beat
// AXI4 transaction and stalls the pipeline until it finishes.
module data_axi_bridge
  import data_axi_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = DATA_AXI_ID,
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              mem_wr,
  input  logic [1:0]        mem_size,
  input  logic [3:0]        mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_err,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              data_on,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  output logic [2:0]        arsize,
  output logic [7:0]        arlen,
  output logic [1:0]        arburst,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              rready,
  input  logic              rlast,
  input  logic [1:0]        rresp,
  output logic [3:0]        awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [2:0]        awsize,
  output logic [7:0]        awlen,
  output logic [1:0]        awburst,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  output logic              wlast,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp
);

  state_e              state_q, state_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                bready_q, bready_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic [3:0]          sel_q, sel_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                req, wr_start, wr_both_done;
  logic                unused_resp;

  assign req         = mem_en & ~mem_err;
  assign unused_resp = &{1'b0, rlast, rresp, bresp};

  // Next-state and registered-output logic for the request FSM.
  always_comb begin
    state_d   = state_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    bready_d  = bready_q;
    addr_d    = addr_q;
    size_d    = size_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    wr_start  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d = mem_addr;
          size_d = mem_size;
          if (mem_wr) begin
            state_d  = ST_WR;
            sel_d    = mem_sel;
            wdata_d  = mem_wdata;
            wr_start = 1'b1;
          end else begin
            state_d   = ST_RD_A;
            arvalid_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_A: begin
        if (arready) begin
          state_d   = ST_RD_D;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else begin
          state_d = ST_RD_A;
        end
      end
      ST_RD_D: begin
        if (rvalid) begin
          state_d  = ST_DONE;
          rready_d = 1'b0;
          rdata_d  = rdata;
        end else begin
          state_d = ST_RD_D;
        end
      end
      ST_WR: begin
        if (wr_both_done) begin
          state_d  = ST_WR_B;
          bready_d = 1'b1;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_WR_B: begin
        if (bvalid) begin
          state_d  = ST_DONE;
          bready_d = 1'b0;
        end else begin
          state_d = ST_WR_B;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d   = ST_IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        bready_d  = 1'b0;
      end
    endcase
  end

  // State registers; load data is cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      bready_q  <= 1'b0;
      addr_q    <= '0;
      size_q    <= 2'd0;
      sel_q     <= 4'd0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      bready_q  <= bready_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  axi_wr_pair u_wr_pair (
    .clk       (clk),
    .rst       (rst),
    .start     (wr_start),
    .awready   (awready),
    .wready    (wready),
    .awvalid   (awvalid),
    .wvalid    (wvalid),
    .both_done (wr_both_done)
  );

  // The IDLE term is combinational so the stall covers the request cycle itself.
  assign data_on = ((state_q == ST_IDLE) & req) | (state_q == ST_RD_A) | (state_q == ST_RD_D) |
                   (state_q == ST_WR) | (state_q == ST_WR_B);

  assign mem_rdata = rdata_q;
  assign arid      = AXI_ID;
  assign araddr    = addr_q;
  assign arvalid   = arvalid_q;
  assign arsize    = axi_size(size_q);
  assign arlen     = 8'd0;
  assign arburst   = AXI_BURST_INCR;
  assign rready    = rready_q;
  assign awid      = AXI_ID;
  assign awaddr    = addr_q;
  assign awsize    = axi_size(size_q);
  assign awlen     = 8'd0;
  assign awburst   = AXI_BURST_INCR;
  assign wdata     = wdata_q;
  assign wstrb     = sel_q;
  assign wlast     = 1'b1;
  assign bready    = bready_q;

endmodule

// File: tb/tb_data_axi_bridge.sv
// Self-checking bench for data_axi_bridge: an AXI responder with programmable
// per-channel delays, plus read/write scoreboards checked by per-feature tasks.
module tb_data_axi_bridge;

  typedef struct packed {
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, mem_wr, mem_err;
  logic [1:0]  mem_size;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        data_on;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr, wdata;
  logic        arvalid, rready, awvalid, wvalid, bready, wlast;
  logic [2:0]  arsize, awsize;
  logic [7:0]  arlen, awlen;
  logic [1:0]  arburst, awburst;
  logic [3:0]  wstrb;
  logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic        rlast;
  logic [1:0]  rresp, bresp;

  assign rlast = 1'b1;
  assign rresp = 2'b00;
  assign bresp = 2'b00;

  always #5 clk = ~clk;

  data_axi_bridge dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_err(mem_err),
    .mem_rdata(mem_rdata), .data_on(data_on),
    .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready), .arsize(arsize),
    .arlen(arlen), .arburst(arburst),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .rlast(rlast), .rresp(rresp),
    .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awsize(awsize),
    .awlen(awlen), .awburst(awburst),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  // Scoreboards: expectations pushed by tests, captures pushed by the responder.
  logic [31:0] rd_exp_q[$];
  wr_t         wr_exp_q[$];
  wr_t         wr_cap_q[$];
  logic [34:0] ar_cap_q[$];
  int          wr_idx = 0;
  int          ar_idx = 0;

  int n_checks = 0;
  int n_fail   = 0;

  // Responder configuration and state.
  int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [31:0] r_data_val = 32'd0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  bit r_pend = 0, r_fire = 0, b_pend = 0, b_fire = 0, aw_got = 0, w_got = 0;
  bit ar_wait = 0, aw_wait = 0, w_wait = 0;
  logic [31:0] ar_last_addr, aw_last_addr, w_last_data;
  logic [2:0]  ar_last_size, aw_last_size;
  logic [3:0]  w_last_strb;
  wr_t         cap;
  int ar_count = 0, aw_count = 0, w_count = 0, b_count = 0;
  int unstable = 0, valid_after_hs = 0, bready_early = 0;

  // AXI responder: decides readies/valids at negedge for the following posedge.
  always @(negedge clk) begin
    if (rst) begin
      arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      r_pend = 0; r_fire = 0; b_pend = 0; b_fire = 0; aw_got = 0; w_got = 0;
      ar_wait = 0; aw_wait = 0; w_wait = 0;
    end else begin
      if (r_fire) begin rvalid = 1'b0; r_fire = 0; end
      if (r_pend && !rvalid) begin
        if (r_cnt >= r_delay) begin rvalid = 1'b1; rdata = r_data_val; end
        else r_cnt++;
      end
      if (rvalid && rready) begin r_fire = 1; r_pend = 0; end

      if (arvalid) begin
        if (ar_wait && (araddr !== ar_last_addr || arsize !== ar_last_size)) unstable++;
        ar_last_addr = araddr; ar_last_size = arsize;
        if (ar_cnt >= ar_delay) arready = 1'b1;
        else begin arready = 1'b0; ar_cnt++; end
        if (arready) begin
          ar_count++; ar_cnt = 0; ar_wait = 0; r_pend = 1; r_cnt = 0;
          ar_cap_q.push_back({arsize, araddr});
        end else ar_wait = 1;
      end else begin
        arready = 1'b0; ar_cnt = 0; ar_wait = 0;
      end

      if (b_fire) begin bvalid = 1'b0; b_fire = 0; end
      if (bready && !(aw_got && w_got)) bready_early++;
      if (b_pend && !bvalid) begin
        if (b_cnt >= b_delay) bvalid = 1'b1;
        else b_cnt++;
      end
      if (bvalid && bready) begin
        b_fire = 1; b_pend = 0; b_count++; aw_got = 0; w_got = 0;
      end

      if (aw_got && awvalid) valid_after_hs++;
      if (awvalid && !aw_got) begin
        if (aw_wait && (awaddr !== aw_last_addr || awsize !== aw_last_size)) unstable++;
        aw_last_addr = awaddr; aw_last_size = awsize;
        if (aw_cnt >= aw_delay) awready = 1'b1;
        else begin awready = 1'b0; aw_cnt++; end
        if (awready) begin
          aw_count++; aw_cnt = 0; aw_wait = 0; aw_got = 1;
          cap.addr = awaddr; cap.size = awsize;
        end else aw_wait = 1;
      end else begin
        awready = 1'b0; aw_cnt = 0; aw_wait = 0;
      end

      if (w_got && wvalid) valid_after_hs++;
      if (wvalid && !w_got) begin
        if (w_wait && (wdata !== w_last_data || wstrb !== w_last_strb)) unstable++;
        w_last_data = wdata; w_last_strb = wstrb;
        if (w_cnt >= w_delay) wready = 1'b1;
        else begin wready = 1'b0; w_cnt++; end
        if (wready) begin
          w_count++; w_cnt = 0; w_wait = 0; w_got = 1;
          cap.data = wdata; cap.strb = wstrb;
        end else w_wait = 1;
      end else begin
        wready = 1'b0; w_cnt = 0; w_wait = 0;
      end

      if (aw_got && w_got && !b_pend && !bvalid) begin
        b_pend = 1; b_cnt = 0;
        wr_cap_q.push_back(cap);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                       input logic [3:0] sel, input logic [31:0] wd);
    mem_en = 1'b1; mem_err = 1'b0; mem_wr = wr; mem_addr = addr;
    mem_size = size; mem_sel = sel; mem_wdata = wd;
  endtask

  // Ticks until data_on drops (the DONE cycle); bounded.
  task automatic wait_done(output int cyc, output bit timed_out);
    cyc = 0;
    timed_out = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (!data_on) begin
        cyc = i;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_en = 1'b0; mem_err = 1'b0; mem_wr = 1'b0;
    mem_addr = 32'd0; mem_size = 2'd0; mem_sel = 4'd0; mem_wdata = 32'd0;
    repeat (3) tick();
    n_checks++;
    if ({arvalid, rready, awvalid, wvalid, bready, data_on} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: ar/r/aw/w/b/data_on=%b required 000000",
               {arvalid, rready, awvalid, wvalid, bready, data_on});
    end
    n_checks++;
    if (mem_rdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_rdata: got %h required 00000000", mem_rdata);
    end
    n_checks++;
    if ({arid, awid, arlen, awlen, arburst, awburst, wlast} !== {4'd1, 4'd1, 8'd0, 8'd0, 2'b01, 2'b01, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_consts: id=%h/%h len=%h/%h burst=%b/%b wlast=%b required 1/1 00/00 01/01 1",
               arid, awid, arlen, awlen, arburst, awburst, wlast);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({arvalid, awvalid, wvalid, data_on} !== 4'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got %b required 0000", {arvalid, awvalid, wvalid, data_on});
    end
  endtask

  task automatic test_zero_wait_load();
    int cyc; bit to;
    ar_delay = 0; r_delay = 0; r_data_val = 32'hDEAD_BEEF;
    tick();
    drive(1'b0, 32'h1FC0_0010, 2'd2, 4'hF, 32'd0);
    rd_exp_q.push_back(32'hDEAD_BEEF);
    #1;
    n_checks++;
    if (data_on !== 1'b1) begin n_fail++; $display("FAIL zw_stall_c0: data_on=%b required 1", data_on); end
    tick();
    n_checks++;
    if ({arvalid, data_on} !== 2'b11) begin
      n_fail++; $display("FAIL zw_arvalid_c1: arvalid,data_on=%b required 11", {arvalid, data_on});
    end
    wait_done(cyc, to);
    mem_en = 1'b0;
    n_checks++;
    if (to || cyc != 2) begin
      n_fail++; $display("FAIL zw_done_cycle: done at cycle %0d (timeout=%0d) required 3", cyc + 1, to);
    end
    n_checks++;
    if (mem_rdata !== rd_exp_q.pop_front()) begin
      n_fail++; $display("FAIL zw_rdata: got %h required deadbeef", mem_rdata);
    end
    n_checks++;
    if (ar_cap_q.size() <= ar_idx || ar_cap_q[ar_idx] !== {3'd2, 32'h1FC0_0010}) begin
      n_fail++; $display("FAIL zw_ar_capture: %0d captured, required arsize=2 araddr=1fc00010", ar_cap_q.size());
    end
    ar_idx++;
  endtask

  task automatic test_delayed_load();
    int cyc; bit to; int ar0;
    ar_delay = 3; r_delay = 2; r_data_val = 32'h0000_00A5; ar0 = ar_count;
    tick();
    drive(1'b0, 32'h0000_1233, 2'd0, 4'h0, 32'd0);
    rd_exp_q.push_back(32'h0000_00A5);
    wait_done(cyc, to);
    mem_en = 1'b0;
    n_checks++;
    if (to || cyc != 8) begin
      n_fail++; $display("FAIL dl_done_cycle: done at cycle %0d (timeout=%0d) required 8", cyc, to);
    end
    n_checks++;
    if (mem_rdata !== rd_exp_q.pop_front()) begin
      n_fail++; $display("FAIL dl_rdata: got %h required 000000a5", mem_rdata);
    end
    n_checks++;
    if (ar_count - ar0 != 1 || unstable != 0) begin
      n_fail++; $display("FAIL dl_ar_once: handshakes=%0d unstable=%0d required 1/0", ar_count - ar0, unstable);
    end
    n_checks++;
    if (ar_cap_q.size() <= ar_idx || ar_cap_q[ar_idx] !== {3'd0, 32'h0000_1233}) begin
      n_fail++; $display("FAIL dl_ar_capture: required arsize=0 araddr=00001233");
    end
    ar_idx++;
  endtask

  task automatic test_store_w_first();
    int cyc; bit to; int aw0, w0, b0;
    aw_delay = 4; w_delay = 1; b_delay = 0;
    aw0 = aw_count; w0 = w_count; b0 = b_count;
    tick();
    drive(1'b1, 32'h8000_0002, 2'd1, 4'b0011, 32'h0000_BEEF);
    wr_exp_q.push_back('{size: 3'd1, addr: 32'h8000_0002, data: 32'h0000_BEEF, strb: 4'b0011});
    wait_done(cyc, to);
    mem_en = 1'b0;
    n_checks++;
    if (to || cyc != 7) begin
      n_fail++; $display("FAIL sw_done_cycle: done at cycle %0d (timeout=%0d) required 7", cyc, to);
    end
    n_checks++;
    if (aw_count - aw0 != 1 || w_count - w0 != 1 || b_count - b0 != 1) begin
      n_fail++; $display("FAIL sw_handshakes: aw=%0d w=%0d b=%0d required 1/1/1",
                         aw_count - aw0, w_count - w0, b_count - b0);
    end
    n_checks++;
    if (bready_early != 0 || valid_after_hs != 0 || unstable != 0) begin
      n_fail++; $display("FAIL sw_protocol: bready_early=%0d valid_after_hs=%0d unstable=%0d required 0/0/0",
                         bready_early, valid_after_hs, unstable);
    end
    n_checks++;
    if (wr_cap_q.size() <= wr_idx || wr_cap_q[wr_idx] !== wr_exp_q.pop_front()) begin
      n_fail++; $display("FAIL sw_scoreboard: captured %0d writes, required size=1 addr=80000002 data=0000beef strb=0011",
                         wr_cap_q.size());
    end
    wr_idx++;
    tick();
    n_checks++;
    if ({data_on, awvalid, wvalid, bready} !== 4'b0) begin
      n_fail++; $display("FAIL sw_single_done: after DONE got %b required 0000", {data_on, awvalid, wvalid, bready});
    end
  endtask

  task automatic test_same_cycle_b_delay();
    int cyc; bit to; int b0;
    aw_delay = 0; w_delay = 0; b_delay = 5; b0 = b_count;
    tick();
    drive(1'b1, 32'h0000_0100, 2'd2, 4'b0000, 32'h1234_5678);
    wr_exp_q.push_back('{size: 3'd2, addr: 32'h0000_0100, data: 32'h1234_5678, strb: 4'b0000});
    tick();
    tick();
    n_checks++;
    if ({awvalid, wvalid, bready, data_on} !== 4'b0011) begin
      n_fail++; $display("FAIL sc_wrb_entry: aw,w,bready,data_on=%b required 0011", {awvalid, wvalid, bready, data_on});
    end
    wait_done(cyc, to);
    mem_en = 1'b0;
    n_checks++;
    if (to || cyc != 6) begin
      n_fail++; $display("FAIL sc_done_cycle: done at cycle %0d (timeout=%0d) required 8", cyc + 2, to);
    end
    n_checks++;
    if (b_count - b0 != 1 || bready_early != 0 || valid_after_hs != 0) begin
      n_fail++; $display("FAIL sc_protocol: b=%0d bready_early=%0d valid_after_hs=%0d required 1/0/0",
                         b_count - b0, bready_early, valid_after_hs);
    end
    n_checks++;
    if (wr_cap_q.size() <= wr_idx || wr_cap_q[wr_idx] !== wr_exp_q.pop_front()) begin
      n_fail++; $display("FAIL sc_scoreboard: required size=2 addr=00000100 data=12345678 strb=0000");
    end
    wr_idx++;
  endtask

  task automatic test_mem_err();
    int ar0, aw0; logic [31:0] held;
    ar0 = ar_count; aw0 = aw_count; held = mem_rdata;
    tick();
    drive(1'b0, 32'h0000_0003, 2'd2, 4'hF, 32'd0);
    mem_err = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if ({arvalid, awvalid, wvalid, data_on} !== 4'b0) begin
        n_fail++; $display("FAIL err_quiet: cycle %0d ar,aw,w,data_on=%b required 0000", i, {arvalid, awvalid, wvalid, data_on});
      end
      tick();
    end
    mem_en = 1'b0; mem_err = 1'b0;
    n_checks++;
    if (ar_count != ar0 || aw_count != aw0 || mem_rdata !== held) begin
      n_fail++; $display("FAIL err_no_axi: ar=%0d aw=%0d rdata=%h required 0/0/%h",
                         ar_count - ar0, aw_count - aw0, mem_rdata, held);
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit to; int ar0;
    ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0;
    r_data_val = 32'h1357_9BDF; ar0 = ar_count;
    tick();
    drive(1'b0, 32'h0000_0040, 2'd2, 4'hF, 32'd0);
    rd_exp_q.push_back(32'h1357_9BDF);
    wait_done(cyc, to);
    n_checks++;
    if (to || cyc != 3 || mem_rdata !== rd_exp_q.pop_front()) begin
      n_fail++; $display("FAIL b2b_load: done cycle %0d rdata=%h required 3/13579bdf", cyc, mem_rdata);
    end
    drive(1'b1, 32'h0000_0044, 2'd2, 4'hF, 32'hCAFE_F00D);
    wr_exp_q.push_back('{size: 3'd2, addr: 32'h0000_0044, data: 32'hCAFE_F00D, strb: 4'hF});
    tick();
    n_checks++;
    if ({data_on, arvalid, awvalid} !== 3'b100) begin
      n_fail++; $display("FAIL b2b_idle_stall: data_on,ar,aw=%b required 100", {data_on, arvalid, awvalid});
    end
    tick();
    n_checks++;
    if ({awvalid, wvalid, arvalid} !== 3'b110) begin
      n_fail++; $display("FAIL b2b_store_issue: aw,w,ar=%b required 110", {awvalid, wvalid, arvalid});
    end
    wait_done(cyc, to);
    mem_en = 1'b0;
    n_checks++;
    if (to || cyc != 2 || ar_count - ar0 != 1) begin
      n_fail++; $display("FAIL b2b_store_done: cycles=%0d ar=%0d required 2/1", cyc, ar_count - ar0);
    end
    n_checks++;
    if (wr_cap_q.size() <= wr_idx || wr_cap_q[wr_idx] !== wr_exp_q.pop_front()) begin
      n_fail++; $display("FAIL b2b_scoreboard: required addr=00000044 data=cafef00d strb=1111");
    end
    wr_idx++;
    n_checks++;
    if (mem_rdata !== 32'h1357_9BDF) begin
      n_fail++; $display("FAIL b2b_rdata_hold: got %h required 13579bdf", mem_rdata);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    ar_delay = 0; r_delay = 10; r_data_val = 32'h5555_AAAA; seen = 1'b0;
    tick();
    drive(1'b0, 32'h0000_0080, 2'd2, 4'hF, 32'd0);
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = rready;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rm_reach_rd_d: rready=0 required 1"); end
    tick();
    rst = 1'b1; mem_en = 1'b0;
    tick();
    n_checks++;
    if ({arvalid, rready, awvalid, wvalid, bready, data_on} !== 6'b0 || mem_rdata !== 32'd0) begin
      n_fail++; $display("FAIL rm_reset: ctl=%b rdata=%h required 000000/00000000",
                         {arvalid, rready, awvalid, wvalid, bready, data_on}, mem_rdata);
    end
    rst = 1'b0;
    r_delay = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_zero_wait_load();
    test_delayed_load();
    test_store_w_first();
    test_same_cycle_b_delay();
    test_mem_err();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
